// File: rtl/disp_pkg.sv
// Shared constants for the BCD display formatter: segment patterns, conversion sizing,
// FSM state encoding and the double-dabble digit adjust helper.
package disp_pkg;

  localparam int unsigned NumIters  = 16;
  localparam int unsigned NumDigits = 5;
  localparam int unsigned BcdWidth  = 4 * NumDigits;
  localparam int unsigned NumPos    = NumDigits + 1;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] Seg0     = 7'b1000000;
  localparam logic [6:0] Seg1     = 7'b1111001;
  localparam logic [6:0] Seg2     = 7'b0100100;
  localparam logic [6:0] Seg3     = 7'b0110000;
  localparam logic [6:0] Seg4     = 7'b0011001;
  localparam logic [6:0] Seg5     = 7'b0010010;
  localparam logic [6:0] Seg6     = 7'b0000010;
  localparam logic [6:0] Seg7     = 7'b1111000;
  localparam logic [6:0] Seg8     = 7'b0000000;
  localparam logic [6:0] Seg9     = 7'b0010000;
  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegMinus = 7'b0111111;

  // Non-decimal character code carried alongside BCD digits to select the minus sign
  localparam logic [3:0] CodeMinus = 4'hA;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StConvert = 2'd1,
    StDone    = 2'd2
  } state_e;

  function automatic logic [BcdWidth-1:0] dabble_adjust(input logic [BcdWidth-1:0] bcd);
    logic [BcdWidth-1:0] adj;
    for (int i = 0; i < int'(NumDigits); i++) begin
      adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    return adj;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational character decoder: BCD digit, minus code or blank to an active-low
// seven-segment pattern.
module seg_decoder
  import disp_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SegBlank;
    if (!blank_i) begin
      case (code_i)
        4'd0:      seg_o = Seg0;
        4'd1:      seg_o = Seg1;
        4'd2:      seg_o = Seg2;
        4'd3:      seg_o = Seg3;
        4'd4:      seg_o = Seg4;
        4'd5:      seg_o = Seg5;
        4'd6:      seg_o = Seg6;
        4'd7:      seg_o = Seg7;
        4'd8:      seg_o = Seg8;
        4'd9:      seg_o = Seg9;
        CodeMinus: seg_o = SegMinus;
        default:   seg_o = SegBlank;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_formatter.sv
// Converts a signed 16-bit product to a 6-character sign+BCD field with leading-zero
// blanking and presents a scrollable 4-character window to the display scanner.
module bcd_display_formatter
  import disp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] product,
  input  logic        scroll_l,
  input  logic        scroll_r,
  output logic [6:0]  seg0,
  output logic [6:0]  seg1,
  output logic [6:0]  seg2,
  output logic [6:0]  seg3,
  output logic        dp0,
  output logic        dp1,
  output logic        dp2,
  output logic        dp3,
  output logic        busy,
  output logic        ready
);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                sign_q, sign_d;
  logic [15:0]         mag_q, mag_d;
  logic [BcdWidth-1:0] bcd_q, bcd_d;
  logic                res_valid_q, res_valid_d;
  logic                res_neg_q, res_neg_d;
  logic [BcdWidth-1:0] res_bcd_q, res_bcd_d;
  logic [1:0]          w_q, w_d;

  logic                done_entry;
  logic [BcdWidth-1:0] bcd_adj;

  assign bcd_adj = dabble_adjust(bcd_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    bcd_d       = bcd_q;
    res_valid_d = res_valid_q;
    res_neg_d   = res_neg_q;
    res_bcd_d   = res_bcd_q;
    done_entry  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (load) begin
          state_d = StConvert;
          cnt_d   = '0;
          // A set MSB implies a nonzero magnitude, so the sign alone decides the minus
          sign_d  = product[15];
          mag_d   = product[15] ? (~product + 16'd1) : product;
          bcd_d   = '0;
        end
      end
      StConvert: begin
        bcd_d = {bcd_adj[BcdWidth-2:0], mag_q[15]};
        mag_d = {mag_q[14:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(NumIters - 1)) begin
          state_d     = StDone;
          done_entry  = 1'b1;
          res_valid_d = 1'b1;
          res_neg_d   = sign_q;
          res_bcd_d   = bcd_d;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    w_d = w_q;
    if (done_entry) begin
      w_d = 2'd0;
    end else if (scroll_l && !scroll_r && (w_q != 2'd2)) begin
      w_d = w_q + 2'd1;
    end else if (scroll_r && !scroll_l && (w_q != 2'd0)) begin
      w_d = w_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      bcd_q       <= '0;
      res_valid_q <= 1'b0;
      res_neg_q   <= 1'b0;
      res_bcd_q   <= '0;
      w_q         <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      bcd_q       <= bcd_d;
      res_valid_q <= res_valid_d;
      res_neg_q   <= res_neg_d;
      res_bcd_q   <= res_bcd_d;
      w_q         <= w_d;
    end
  end

  assign busy  = (state_q == StConvert);
  assign ready = (state_q == StDone);

  // Full character field, position 5 is the sign slot
  logic [3:0] pos_code  [NumPos];
  logic       pos_blank [NumPos];

  always_comb begin
    logic seen;
    seen = 1'b0;
    for (int p = int'(NumDigits) - 1; p >= 0; p--) begin
      pos_code[p]  = res_bcd_q[4*p +: 4];
      seen         = seen | (res_bcd_q[4*p +: 4] != 4'd0) | (p == 0);
      pos_blank[p] = !res_valid_q || !seen;
    end
    pos_code[NumPos-1]  = CodeMinus;
    pos_blank[NumPos-1] = !(res_valid_q && res_neg_q);
  end

  logic [3:0] win_code  [4];
  logic       win_blank [4];
  logic       hidden_left;

  always_comb begin
    logic [2:0] idx;
    hidden_left = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx          = {1'b0, w_q} + 3'(k);
      win_code[k]  = CodeMinus;
      win_blank[k] = 1'b1;
      if (idx < 3'(NumPos)) begin
        win_code[k]  = pos_code[idx];
        win_blank[k] = pos_blank[idx];
      end
    end
    for (int p = 0; p < int'(NumPos); p++) begin
      if ((3'(p) > ({1'b0, w_q} + 3'd3)) && !pos_blank[p]) begin
        hidden_left = 1'b1;
      end
    end
  end

  logic [6:0] seg_win [4];

  for (genvar k = 0; k < 4; k++) begin : g_dec
    seg_decoder u_dec (
      .code_i  (win_code[k]),
      .blank_i (win_blank[k]),
      .seg_o   (seg_win[k])
    );
  end

  assign seg0 = seg_win[0];
  assign seg1 = seg_win[1];
  assign seg2 = seg_win[2];
  assign seg3 = seg_win[3];

  assign dp0 = (w_q == 2'd0);
  assign dp1 = 1'b1;
  assign dp2 = 1'b1;
  assign dp3 = !hidden_left;

endmodule

// File: tb/tb_bcd_display_formatter.sv
// Bench for bcd_display_formatter: directed vector table, hand-written corner sequences
// and randomized traffic compared every cycle against a decimal-arithmetic model.
module tb_bcd_display_formatter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] product = 16'd0;
  logic        scroll_l = 1'b0;
  logic        scroll_r = 1'b0;
  logic [6:0]  seg0, seg1, seg2, seg3;
  logic        dp0, dp1, dp2, dp3, busy, ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_display_formatter dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .product  (product),
    .scroll_l (scroll_l),
    .scroll_r (scroll_r),
    .seg0     (seg0),
    .seg1     (seg1),
    .seg2     (seg2),
    .seg3     (seg3),
    .dp0      (dp0),
    .dp1      (dp1),
    .dp2      (dp2),
    .dp3      (dp3),
    .busy     (busy),
    .ready    (ready)
  );

  localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000, P4 = 7'b0011001, P5 = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010, P7 = 7'b1111000, P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0010000, PB = 7'b1111111, PM = 7'b0111111;
  localparam logic [3:0] CMinus = 4'd10, CBlank = 4'd15;

  function automatic logic [6:0] pat(input logic [3:0] c);
    case (c)
      4'd0: return P0;  4'd1: return P1;  4'd2: return P2;  4'd3: return P3;
      4'd4: return P4;  4'd5: return P5;  4'd6: return P6;  4'd7: return P7;
      4'd8: return P8;  4'd9: return P9;  CMinus: return PM;
      default: return PB;
    endcase
  endfunction

  // Character field (6 x 4-bit codes) from plain decimal arithmetic on the signed value
  function automatic logic [23:0] field_of(input logic [15:0] p);
    int v, m, top;
    int d[5];
    logic [23:0] f;
    v = int'($signed(p));
    m = (v < 0) ? -v : v;
    for (int i = 0; i < 5; i++) begin
      d[i] = m % 10;
      m = m / 10;
    end
    top = 0;
    for (int i = 0; i < 5; i++) if (d[i] != 0) top = i;
    f = '1;
    for (int i = 0; i < 5; i++) if (i <= top) f[4*i +: 4] = 4'(d[i]);
    if (v < 0) f[23:20] = CMinus;
    return f;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check7(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: conversion countdown, latched field, window offset
  int          m_left = 0;
  logic [15:0] m_pend = '0;
  logic [23:0] m_field = '1;
  int          m_w = 0;
  logic        m_ready = 1'b0;
  bit          m_done_now;

  function automatic logic [6:0] exp_seg(input int k);
    int p;
    p = m_w + k;
    return pat(m_field[4*p +: 4]);
  endfunction

  function automatic logic exp_dp3();
    for (int p = 0; p < 6; p++) if (p > m_w + 3 && m_field[4*p +: 4] != CBlank) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_left  = 0;
      m_field = '1;
      m_w     = 0;
      m_ready = 1'b0;
    end else begin
      m_done_now = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done_now = 1'b1;
          m_field    = field_of(m_pend);
          m_ready    = 1'b1;
        end
      end else if (load) begin
        m_left  = 16;
        m_pend  = product;
        m_ready = 1'b0;
      end
      if (m_done_now) m_w = 0;
      else if (scroll_l && !scroll_r) m_w = (m_w < 2) ? m_w + 1 : 2;
      else if (scroll_r && !scroll_l) m_w = (m_w > 0) ? m_w - 1 : 0;
    end
    #1;
    check1("m_busy", busy, m_left > 0);
    check1("m_ready", ready, m_ready);
    check7("m_seg0", seg0, exp_seg(0));
    check7("m_seg1", seg1, exp_seg(1));
    check7("m_seg2", seg2, exp_seg(2));
    check7("m_seg3", seg3, exp_seg(3));
    check1("m_dp0", dp0, m_w == 0);
    check1("m_dp1", dp1, 1'b1);
    check1("m_dp2", dp2, 1'b1);
    check1("m_dp3", dp3, exp_dp3());
  end

  typedef struct {
    logic [15:0] prod;
    int          nscroll;
    logic [6:0]  s3, s2, s1, s0;
    logic        e_dp3, e_dp0;
  } vec_t;

  vec_t vecs[10];

  task automatic run_load(input logic [15:0] prod, output int busy_n, output int ready_at);
    @(negedge clk);
    load    = 1'b1;
    product = prod;
    busy_n  = 0;
    ready_at = 0;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk);
      #2;
      if (c == 1) load = 1'b0;
      if (busy) busy_n++;
      if (ready && ready_at == 0) ready_at = c;
    end
  endtask

  task automatic scroll_pulse(input logic l, input logic r);
    @(negedge clk);
    scroll_l = l;
    scroll_r = r;
    @(negedge clk);
    scroll_l = 1'b0;
    scroll_r = 1'b0;
  endtask

  task automatic check_win(input string name, input logic [6:0] s3, input logic [6:0] s2,
                           input logic [6:0] s1, input logic [6:0] s0);
    check7({name, "_seg3"}, seg3, s3);
    check7({name, "_seg2"}, seg2, s2);
    check7({name, "_seg1"}, seg1, s1);
    check7({name, "_seg0"}, seg0, s0);
  endtask

  initial begin
    int bn, ra;

    vecs[0] = '{16'd1234, 0, P1, P2, P3, P4, 1'b1, 1'b1};
    vecs[1] = '{16'hC000, 0, P6, P3, P8, P4, 1'b0, 1'b1};
    vecs[2] = '{16'hC000, 2, PM, P1, P6, P3, 1'b1, 1'b0};
    vecs[3] = '{16'hC000, 3, PM, P1, P6, P3, 1'b1, 1'b0};
    vecs[4] = '{16'h0000, 0, PB, PB, PB, P0, 1'b1, 1'b1};
    vecs[5] = '{16'h8000, 0, P2, P7, P6, P8, 1'b0, 1'b1};
    vecs[6] = '{16'h8000, 2, PM, P3, P2, P7, 1'b1, 1'b0};
    vecs[7] = '{16'd99,   0, PB, PB, P9, P9, 1'b1, 1'b1};
    vecs[8] = '{16'hFFFF, 0, PB, PB, PB, P1, 1'b0, 1'b1};
    vecs[9] = '{16'h7FFF, 1, P3, P2, P7, P6, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    check_win("reset", PB, PB, PB, PB);
    check1("reset_busy", busy, 1'b0);
    check1("reset_ready", ready, 1'b0);
    check1("reset_dp0", dp0, 1'b1);
    check1("reset_dp3", dp3, 1'b1);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_load(vecs[i].prod, bn, ra);
      checki("vec_busy_cycles", bn, 16);
      checki("vec_ready_cycle", ra, 17);
      for (int s = 0; s < vecs[i].nscroll; s++) scroll_pulse(1'b1, 1'b0);
      @(posedge clk);
      #2;
      check_win("vec", vecs[i].s3, vecs[i].s2, vecs[i].s1, vecs[i].s0);
      check1("vec_dp3", dp3, vecs[i].e_dp3);
      check1("vec_dp0", dp0, vecs[i].e_dp0);
      check1("vec_dp1", dp1, 1'b1);
      check1("vec_dp2", dp2, 1'b1);
    end

    // Second load during conversion is ignored
    @(negedge clk);
    load = 1'b1;
    product = 16'd1234;
    ra = 0;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk);
      #2;
      if (c == 1) load = 1'b0;
      if (c == 5) begin
        load = 1'b1;
        product = 16'd5555;
      end
      if (c == 6) load = 1'b0;
      if (ready && ra == 0) ra = c;
    end
    checki("ignore_ready_cycle", ra, 17);
    check_win("ignore", P1, P2, P3, P4);

    // Simultaneous scrolls leave the window alone
    run_load(16'hC000, bn, ra);
    scroll_pulse(1'b1, 1'b0);
    scroll_pulse(1'b1, 1'b1);
    @(posedge clk);
    #2;
    check_win("both", P1, P6, P3, P8);
    check1("both_dp0", dp0, 1'b0);
    check1("both_dp3", dp3, 1'b0);

    // Load in DONE drops ready next cycle; display holds the old result
    @(negedge clk);
    load = 1'b1;
    product = 16'd99;
    @(posedge clk);
    #2;
    load = 1'b0;
    check1("reload_ready", ready, 1'b0);
    check1("reload_busy", busy, 1'b1);
    check_win("reload_hold", P1, P6, P3, P8);

    // Reset mid-conversion, then a normal conversion
    rst = 1'b0;
    for (int c = 2; c <= 8; c++) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_win("abort", PB, PB, PB, PB);
    check1("abort_busy", busy, 1'b0);
    check1("abort_ready", ready, 1'b0);
    check1("abort_dp0", dp0, 1'b1);
    check1("abort_dp3", dp3, 1'b1);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_load(16'd99, bn, ra);
    checki("after_rst_ready_cycle", ra, 17);
    check_win("after_rst", PB, PB, P9, P9);

    // Randomized traffic, checked by the per-cycle model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      load = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 5))
        0: product = 16'h8000;
        1: product = 16'h0000;
        2: product = 16'hFFFF;
        default: product = 16'($urandom);
      endcase
      scroll_l = ($urandom_range(0, 3) == 0);
      scroll_r = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    load = 1'b0;
    scroll_l = 1'b0;
    scroll_r = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
